// File: rtl/mux_lut_pkg.sv
// Shared opcode encoding, per-opcode truth tables and the opcode-to-table decode
// for the mux_lut_gate_unit pipeline.
package mux_lut_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_LUT    = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  // Table bit index is {a,b}: bit0 -> a=0,b=0 ... bit3 -> a=1,b=1.
  localparam logic [3:0] TBL_AND    = 4'b1000;
  localparam logic [3:0] TBL_OR     = 4'b1110;
  localparam logic [3:0] TBL_NAND   = 4'b0111;
  localparam logic [3:0] TBL_NOR    = 4'b0001;
  localparam logic [3:0] TBL_XOR    = 4'b0110;
  localparam logic [3:0] TBL_XNOR   = 4'b1001;
  localparam logic [3:0] TBL_PASS_A = 4'b1100;

  function automatic logic [3:0] op_to_table(input logic [2:0] op, input logic [3:0] lut);
    logic [3:0] tbl;
    case (op)
      OP_AND:    tbl = TBL_AND;
      OP_OR:     tbl = TBL_OR;
      OP_NAND:   tbl = TBL_NAND;
      OP_NOR:    tbl = TBL_NOR;
      OP_XOR:    tbl = TBL_XOR;
      OP_XNOR:   tbl = TBL_XNOR;
      OP_PASS_A: tbl = TBL_PASS_A;
      default:   tbl = lut;
    endcase
    return tbl;
  endfunction

endpackage

// File: rtl/mux4_lane.sv
// One bit lane: a 4:1 mux built from three 2:1 muxes; select {a,b} indexes the truth table.
module mux4_lane (
  input  logic       a,
  input  logic       b,
  input  logic [3:0] tbl,
  output logic       y
);

  logic lo;
  logic hi;

  // b picks within each half of the table, a picks the half.
  mux_2to1 u_mux_lo (.d0(tbl[0]), .d1(tbl[1]), .s(b), .y(lo));
  mux_2to1 u_mux_hi (.d0(tbl[2]), .d1(tbl[3]), .s(b), .y(hi));
  mux_2to1 u_mux_out (.d0(lo), .d1(hi), .s(a), .y(y));

endmodule

// File: rtl/mux_2to1.sv
// Single-bit 2:1 multiplexer, the leaf cell of each bit lane.
module mux_2to1 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_lut_gate_unit.sv
// Two-stage valid/ready pipeline computing any 2-input bitwise function of WIDTH-bit operands.
// Optional accepted-result counter on out_count when MUX_LUT_STATS_EN is defined.
module mux_lut_gate_unit
  import mux_lut_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_lut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op
`ifdef MUX_LUT_STATS_EN
  ,
  output logic [15:0]      out_count
`endif
);

  logic             vld_p1;
  logic             vld_p2;
  logic             s2_ready;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [2:0]       op_p1;
  logic [3:0]       tbl_p1;
  logic [WIDTH-1:0] y_lane;
  logic [WIDTH-1:0] y_p2;
  logic [2:0]       op_p2;

  assign s2_ready  = !vld_p2 || out_ready;
  assign in_ready  = !vld_p1 || s2_ready;
  assign out_valid = vld_p2;
  assign out_y     = y_p2;
  assign out_op    = op_p2;

  // Stage 1: capture operands and the decoded table on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_p1   <= in_a;
      b_p1   <= in_b;
      op_p1  <= in_op;
      tbl_p1 <= op_to_table(in_op, in_lut);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux4_lane u_lane (
      .a  (a_p1[i]),
      .b  (b_p1[i]),
      .tbl(tbl_p1),
      .y  (y_lane[i])
    );
  end

  // Stage 2: register lane results; outputs are cleared by reset and only move on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      y_p2   <= '0;
      op_p2  <= '0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        y_p2  <= y_lane;
        op_p2 <= op_p1;
      end
    end
  end

`ifdef MUX_LUT_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= 16'd0;
    end else if (vld_p2 && out_ready) begin
      out_count <= sat_inc16(out_count);
    end
  end
`endif

endmodule

// File: tb/tb_mux_lut_gate_unit.sv
// Scoreboard bench for mux_lut_gate_unit; stats checks compile in with MUX_LUT_STATS_EN.
module tb_mux_lut_gate_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic [3:0]   in_lut;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [2:0]   out_op;
`ifdef MUX_LUT_STATS_EN
  logic [15:0]  out_count;
  int           exp_cnt;
`endif

  typedef struct {
    logic [W-1:0] y;
    logic [2:0]   op;
    int           t;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_fail;
  int   n_acc;
  int   cyc;
  bit   lat_chk;

  mux_lut_gate_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .in_lut   (in_lut),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_op   (out_op)
`ifdef MUX_LUT_STATS_EN
    ,
    .out_count(out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each result bit is table[{a,b}] with the table chosen by opcode.
  function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op, input logic [3:0] lut);
    logic [3:0]   t;
    logic [W-1:0] r;
    case (op)
      3'd0:    t = 4'b1000;
      3'd1:    t = 4'b1110;
      3'd2:    t = 4'b0111;
      3'd3:    t = 4'b0001;
      3'd4:    t = 4'b0110;
      3'd5:    t = 4'b1001;
      3'd6:    t = lut;
      default: t = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", {24'd0, out_y}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("out_y", {24'd0, out_y}, {24'd0, e.y});
        check_eq("out_op", {29'd0, out_op}, {29'd0, e.op});
        if (lat_chk) check_eq("latency", cyc - e.t, 2);
      end
`ifdef MUX_LUT_STATS_EN
      if (exp_cnt < 65535) exp_cnt++;
`endif
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [3:0] lut, input logic [W-1:0] exp);
    bit   done;
    exp_t e;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_lut   = lut;
    in_valid = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y  = exp;
        e.op = op;
        e.t  = cyc;
        q.push_back(e);
        n_acc++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [3:0]   lut;
    a   = W'($urandom);
    b   = W'($urandom);
    op  = 3'($urandom);
    lut = 4'($urandom);
    send(a, b, op, lut, ref_y(a, b, op, lut));
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check_eq("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_acc     = 0;
    lat_chk   = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_lut    = '0;
    out_ready = 1'b1;
`ifdef MUX_LUT_STATS_EN
    exp_cnt = 0;
`endif
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_out_y", {24'd0, out_y}, 0);
    check_eq("rst_out_op", {29'd0, out_op}, 0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 1);
`ifdef MUX_LUT_STATS_EN
    check_eq("rst_count", {16'd0, out_count}, 0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed functions back-to-back, then LUT (in_lut changes on the next beat) and PASS_A
    send(8'hF0, 8'hCC, 3'd0, 4'b0000, 8'hC0);
    send(8'hF0, 8'hCC, 3'd1, 4'b0000, 8'hFC);
    send(8'hF0, 8'hCC, 3'd2, 4'b0000, 8'h3F);
    send(8'hF0, 8'hCC, 3'd3, 4'b0000, 8'h03);
    send(8'hF0, 8'hCC, 3'd4, 4'b0000, 8'h3C);
    send(8'hF0, 8'hCC, 3'd5, 4'b0000, 8'hC3);
    send(8'hF0, 8'hCC, 3'd6, 4'b0100, 8'h30);
    send(8'hF0, 8'hCC, 3'd0, 4'b1111, 8'hC0);
    send(8'hF0, 8'hCC, 3'd7, 4'b1011, 8'hF0);
    for (int k = 0; k < 8; k++) send_rand();
    wait_drain();

    // Backpressure: two held, then in_ready drops; release and expect all four in order
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    begin
      int base;
      base = n_acc;
      fork
        begin
          for (int k = 0; k < 4; k++) begin
            logic [W-1:0] a;
            a = W'(8'h11 * (k + 1));
            send(a, 8'h0F, 3'd4, 4'b0000, ref_y(a, 8'h0F, 3'd4, 4'b0000));
          end
        end
        begin
          repeat (5) @(posedge clk);
          #2;
          check_eq("bp_accepted", n_acc - base, 2);
          check_eq("bp_in_ready", {31'd0, in_ready}, 0);
          check_eq("bp_out_valid", {31'd0, out_valid}, 1);
          out_ready = 1'b1;
        end
      join
    end
    wait_drain();
    lat_chk = 1'b1;

    // Reset with both stages full
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 3'd1, 4'b0000, 8'hFF);
    send(8'h3C, 8'h0F, 3'd0, 4'b0000, 8'h0C);
    check_eq("full_in_ready", {31'd0, in_ready}, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("mid_rst_out_y", {24'd0, out_y}, 0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 1);
`ifdef MUX_LUT_STATS_EN
    check_eq("mid_rst_count", {16'd0, out_count}, 0);
    exp_cnt = 0;
`endif
    q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'h96, 8'hFF, 3'd5, 4'b0000, 8'h96);
    wait_drain();

`ifdef MUX_LUT_STATS_EN
    begin
      int c0;
      c0 = exp_cnt;
      for (int k = 0; k < 10; k++) send_rand();
      wait_drain();
      check_eq("count_10", {16'd0, out_count} - c0, 10);
      check_eq("count_model", {16'd0, out_count}, exp_cnt);
      lat_chk = 1'b0;
      for (int k = exp_cnt; k < 65534; k++) send_rand();
      wait_drain();
      check_eq("count_fffe", {16'd0, out_count}, 32'h0000_FFFE);
      for (int k = 0; k < 3; k++) send_rand();
      wait_drain();
      check_eq("count_sat", {16'd0, out_count}, 32'h0000_FFFF);
      check_eq("count_sat_model", {16'd0, out_count}, exp_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_lut_gate_unit.md
Name: mux_lut_gate_unit

Overview:
- Parametrised, pipelined successor to the fixed six-gate mux block.
- Computes any 2-input bitwise Boolean function over WIDTH-bit operands.
- Each bit lane is a 4:1 mux built from 2:1 muxes, with the truth table as the data inputs.
- Function is chosen per transaction by opcode or a raw 4-bit LUT; results stream out through a 2-stage valid/ready pipeline for datapath and ALU-style consumers.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input transaction valid
- in_ready  output  1  block can accept an input this cycle
- in_a  input  WIDTH  operand A (mux select MSB)
- in_b  input  WIDTH  operand B (mux select LSB)
- in_op  input  3  function opcode
- in_lut  input  4  raw truth table, used only when in_op=LUT
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_y  output  WIDTH  result
- out_op  output  3  opcode that produced out_y
- out_count  output  16  accepted-result count (only with STATS_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Truth table indexing: lut[{a,b}], so bit0 is a=0,b=0 and bit3 is a=1,b=1.
- Opcodes and their tables:
  - 0 AND=4'b1000, 1 OR=4'b1110, 2 NAND=4'b0111, 3 NOR=4'b0001
  - 4 XOR=4'b0110, 5 XNOR=4'b1001, 6 LUT=in_lut, 7 PASS_A=4'b1100
- Handshake: transfer occurs when valid && ready. Producers must hold valid and data stable until accepted.
- Stage 1 (S1):
  - On accept, registers in_a, in_b, in_op and the decoded 4-bit table.
  - Decode happens at input; in_lut is sampled only on the accept cycle.
- Stage 2 (S2):
  - Registers per-bit mux result y[i]=table[{a[i],b[i]}], plus the opcode.
- Ready chain:
  - s2_ready = !s2_valid || out_ready
  - in_ready = !s1_valid || s2_ready
  - in_ready depends combinationally on out_ready; no combinational path from in_valid to in_ready.
- Latency and throughput: 2 cycles from input accept to out_valid with no stall; full throughput of 1 result per cycle.
- Backpressure: with out_ready low, at most 2 transactions are held. in_ready deasserts once both stages are full. No loss, no duplication, order preserved.
- Simultaneous events: S2 draining and S1 advancing in the same cycle is a legal full-rate pass-through.
- Reset (including mid-operation):
  - s1_valid=0, s2_valid=0, out_valid=0, out_y=0, out_op=0, out_count=0.
  - in_ready=1 immediately during reset.
  - In-flight transactions are discarded.
- Outputs: out_y and out_op change only on an S2 load.

Optional Feature:
- Macro: MUX_LUT_STATS_EN.
- Defined:
  - out_count port exists.
  - Increments on each out_valid && out_ready.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mux_lut_pkg:
  - opcode enum (OP_AND..OP_PASS_A)
  - 4-bit table constants per opcode
  - decode function op->table
- Sub-module mux4_lane: 1-bit 4:1 mux composed of three mux_2to1 instances, select {a,b}, data = table.
- Top instantiates WIDTH lanes via generate.

Test Plan:
- WIDTH=8, a=8'hF0, b=8'hCC, ops 0..5 back-to-back, out_ready=1.
  - Expect out_y = C0, FC, 3F, 03, 3C, C3 respectively, each 2 cycles after accept, one per cycle.
- op=LUT, in_lut=4'b0100, a=F0, b=CC → out_y=8'h30.
- op=PASS_A → out_y=F0.
- In the beat after a LUT accept, change in_lut → already-accepted result unaffected.
- Offer 4 transactions with out_ready=0 for 5 cycles:
  - Exactly 2 accepted, then in_ready=0.
  - Release out_ready → all 4 emerge in order, none dropped or duplicated.
- Assert rst_n low mid-stream with both stages full:
  - out_valid=0 and out_y=0 asynchronously, in_ready=1.
  - After release, first new input yields its result 2 cycles later.
- MUX_LUT_STATS_EN defined:
  - 10 accepted results → out_count=10.
  - Preload near 16'hFFFE via a long run, then 3 more results → out_count holds at FFFF.
